// File: rtl/bus_pkg.sv
// Shared widths, FSM encodings, error codes and size encodings for the data-bus fabric.
package bus_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;
  localparam logic [1:0] ST_ERR  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_WAIT = ST_WAIT,
    S_RESP = ST_RESP,
    S_ERR  = ST_ERR
  } state_t;

  localparam logic ERR_DECODE  = 1'b0;
  localparam logic ERR_TIMEOUT = 1'b1;

  typedef enum logic [1:0] {
    HB_BYTE = 2'b00,
    HB_HALF = 2'b01,
    HB_WORD = 2'b10
  } hb_t;

  // Slaves see a window-relative address with the region nibble stripped.
  function automatic logic [ADDR_W-1:0] slave_addr(input logic [ADDR_W-1:0] addr);
    return {4'h0, addr[27:0]};
  endfunction

endpackage

// File: rtl/bus_fabric_if.sv
// Core-side and slave-side bus signals of the fabric, with one modport per party.
interface bus_fabric_if #(
  parameter int unsigned N_SLAVES = 8
) ();
  import bus_pkg::*;

  logic [ADDR_W-1:0]          m_addr;
  logic [DATA_W-1:0]          m_wdata;
  logic                       m_we;
  logic                       m_re;
  logic [1:0]                 m_hb;
  logic                       m_req;
  logic [DATA_W-1:0]          m_rdata;
  logic                       m_gnt;
  logic                       m_err;

  logic [N_SLAVES-1:0]        s_ce;
  logic [ADDR_W-1:0]          s_addr;
  logic [DATA_W-1:0]          s_wdata;
  logic                       s_we;
  logic                       s_re;
  logic [1:0]                 s_hb;
  logic                       s_req;
  logic [N_SLAVES-1:0]        s_gnt;
  logic [DATA_W*N_SLAVES-1:0] s_rdata;

  logic                       err_clr;
  logic                       err_valid;
  logic                       err_code;
  logic [ADDR_W-1:0]          err_addr;

  modport fabric (
    input  m_addr, m_wdata, m_we, m_re, m_hb, m_req,
    output m_rdata, m_gnt, m_err,
    output s_ce, s_addr, s_wdata, s_we, s_re, s_hb, s_req,
    input  s_gnt, s_rdata,
    input  err_clr,
    output err_valid, err_code, err_addr
  );

  modport master (
    output m_addr, m_wdata, m_we, m_re, m_hb, m_req,
    input  m_rdata, m_gnt, m_err,
    output err_clr,
    input  err_valid, err_code, err_addr
  );

  modport slave (
    input  s_ce, s_addr, s_wdata, s_we, s_re, s_hb, s_req,
    output s_gnt, s_rdata
  );

endinterface

// File: rtl/bus_addr_decode.sv
// Region decode: ADDR[31:28] relative to BASE_NIBBLE selects one slave, or misses.
module bus_addr_decode #(
  parameter int unsigned N_SLAVES    = 8,
  parameter logic [3:0]  BASE_NIBBLE = 4'h8
) (
  input  logic [3:0]          addr_nibble,
  output logic [N_SLAVES-1:0] sel,
  output logic                hit
);

  logic [4:0] offset;

  // Nibbles below the base wrap to >= 16 in five bits, so they never match.
  always_comb begin
    offset = {1'b0, addr_nibble} - {1'b0, BASE_NIBBLE};
    sel    = '0;
    hit    = 1'b0;
    for (int unsigned k = 0; k < N_SLAVES; k++) begin
      if (offset == 5'(k)) begin
        sel[k] = 1'b1;
        hit    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_fabric.sv
// Single-master, N-slave data-bus fabric: registered slave select, per-transaction FSM,
// decode-miss and timeout error responses, and a sticky first-error capture register.
module bus_fabric
  import bus_pkg::*;
#(
  parameter int unsigned N_SLAVES    = 8,
  parameter logic [3:0]  BASE_NIBBLE = 4'h8,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic         i_CLK,
  input  logic         i_RST,
  bus_fabric_if.fabric bus
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

  state_t              state_q;
  logic [N_SLAVES-1:0] sel_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                err_kind_q;
  logic                err_valid_q;
  logic                err_code_q;
  logic [ADDR_W-1:0]   err_addr_q;

  logic [N_SLAVES-1:0] dec_sel;
  logic                dec_hit;
  logic                take_req;
  logic                sel_gnt;
  logic [DATA_W-1:0]   sel_rdata;
  logic                in_wait;

  bus_addr_decode #(
    .N_SLAVES    (N_SLAVES),
    .BASE_NIBBLE (BASE_NIBBLE)
  ) u_dec (
    .addr_nibble (bus.m_addr[31:28]),
    .sel         (dec_sel),
    .hit         (dec_hit)
  );

  assign take_req = bus.m_req & (bus.m_re | bus.m_we);
  assign in_wait  = (state_q == S_WAIT);

  // Only the registered selection may grant; other slaves' grants are masked off.
  always_comb begin
    sel_gnt   = |(bus.s_gnt & sel_q);
    sel_rdata = '0;
    for (int unsigned k = 0; k < N_SLAVES; k++) begin
      if (sel_q[k]) begin
        sel_rdata = sel_rdata | bus.s_rdata[DATA_W*k +: DATA_W];
      end
    end
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state_q    <= S_IDLE;
      sel_q      <= '0;
      cnt_q      <= '0;
      rdata_q    <= '0;
      err_kind_q <= ERR_DECODE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (take_req) begin
            if (dec_hit) begin
              sel_q   <= dec_sel;
              cnt_q   <= '0;
              state_q <= S_WAIT;
            end else begin
              err_kind_q <= ERR_DECODE;
              state_q    <= S_ERR;
            end
          end
        end
        S_WAIT: begin
          if (sel_gnt) begin
            rdata_q <= sel_rdata;
            state_q <= S_RESP;
          end else if (cnt_q == CNT_LAST) begin
            err_kind_q <= ERR_TIMEOUT;
            state_q    <= S_ERR;
          end else if (cnt_q != CNT_MAX) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_RESP:  state_q <= S_IDLE;
        S_ERR:   state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // A capture in the same cycle as a clear re-arms the register with the new error.
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      err_valid_q <= 1'b0;
      err_code_q  <= ERR_DECODE;
      err_addr_q  <= '0;
    end else if ((state_q == S_ERR) && (!err_valid_q || bus.err_clr)) begin
      err_valid_q <= 1'b1;
      err_code_q  <= err_kind_q;
      err_addr_q  <= bus.m_addr;
    end else if (bus.err_clr) begin
      err_valid_q <= 1'b0;
    end
  end

  assign bus.m_gnt   = (state_q == S_RESP) || (state_q == S_ERR);
  assign bus.m_err   = (state_q == S_ERR);
  assign bus.m_rdata = (state_q == S_RESP) ? rdata_q : '0;

  assign bus.s_ce    = in_wait ? sel_q : '0;
  assign bus.s_req   = in_wait & bus.m_req;
  assign bus.s_we    = in_wait & bus.m_we;
  assign bus.s_re    = in_wait & bus.m_re;
  assign bus.s_addr  = slave_addr(bus.m_addr);
  assign bus.s_wdata = bus.m_wdata;
  assign bus.s_hb    = bus.m_hb;

  assign bus.err_valid = err_valid_q;
  assign bus.err_code  = err_code_q;
  assign bus.err_addr  = err_addr_q;

endmodule

// File: tb/tb_bus_fabric.sv
// Scoreboard bench for bus_fabric with TIMEOUT=4 and a simple per-slave grant-delay model.
module tb_bus_fabric;
  import bus_pkg::*;

  localparam int unsigned NS = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bus_fabric_if #(.N_SLAVES(NS)) bus ();

  bus_fabric #(
    .N_SLAVES    (NS),
    .BASE_NIBBLE (4'h8),
    .TIMEOUT     (4)
  ) dut (
    .i_CLK (clk),
    .i_RST (rst),
    .bus   (bus.fabric)
  );

  // Slave model: grant after gnt_delay cycles of CE (-1 = never), plus forced grants.
  int          gnt_delay [NS];
  logic [31:0] slv_data  [NS];
  logic [NS-1:0] force_gnt;
  int          ce_cnt    [NS];
  int          ce_cycles;

  initial ce_cycles = 0;

  always @(posedge clk) begin
    for (int k = 0; k < NS; k++) ce_cnt[k] <= bus.s_ce[k] ? ce_cnt[k] + 1 : 0;
    if (bus.s_ce != '0) ce_cycles <= ce_cycles + 1;
  end

  always_comb begin
    bus.s_gnt   = '0;
    bus.s_rdata = '0;
    for (int k = 0; k < NS; k++) begin
      bus.s_gnt[k] = force_gnt[k] |
                     (bus.s_ce[k] && (gnt_delay[k] >= 0) && (ce_cnt[k] == gnt_delay[k]));
      bus.s_rdata[32*k +: 32] = slv_data[k];
    end
  end

  typedef struct {
    logic [31:0] err;
    logic [31:0] rdata;
    int          lat;
    int          ce_cyc;
  } exp_t;

  exp_t sb[$];
  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic txn(input string tag, input logic [31:0] addr, input logic we,
                     input logic [31:0] wdata, input logic clr_on_gnt,
                     input logic err, input logic [31:0] rdata, input int lat,
                     input int ce_cyc);
    exp_t e;
    exp_t got_e;
    int n;
    int ce0;
    logic seen;
    logic got;
    logic [31:0] saddr;
    @(negedge clk);
    e.err = {31'b0, err}; e.rdata = rdata; e.lat = lat; e.ce_cyc = ce_cyc;
    sb.push_back(e);
    bus.m_addr  = addr;
    bus.m_wdata = wdata;
    bus.m_we    = we;
    bus.m_re    = !we;
    bus.m_hb    = HB_WORD;
    bus.m_req   = 1'b1;
    ce0   = ce_cycles;
    n     = 0;
    got   = 1'b0;
    seen  = 1'b0;
    saddr = '0;
    while (!got && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (!seen && bus.s_ce != '0) begin
        seen  = 1'b1;
        saddr = bus.s_addr;
      end
      if (bus.m_gnt) got = 1'b1;
    end
    got_e = sb.pop_front();
    if (got) begin
      check({tag, ".err"},   {31'b0, bus.m_err}, got_e.err);
      check({tag, ".rdata"}, bus.m_rdata, got_e.rdata);
      check({tag, ".lat"},   n, got_e.lat);
      check({tag, ".ce"},    ce_cycles - ce0, got_e.ce_cyc);
      if (seen) check({tag, ".saddr"}, saddr, {4'h0, addr[27:0]});
      if (clr_on_gnt) bus.err_clr = 1'b1;
    end else begin
      check({tag, ".no_gnt"}, 32'd0, 32'd1);
    end
    @(negedge clk);
    bus.m_req = 1'b0;
    bus.m_we  = 1'b0;
    bus.m_re  = 1'b0;
    if (clr_on_gnt) begin
      @(posedge clk); #1;
      bus.err_clr = 1'b0;
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic clear_err();
    @(negedge clk); bus.err_clr = 1'b1;
    @(negedge clk); bus.err_clr = 1'b0;
  endtask

  task automatic check_err(input string tag, input logic v, input logic c, input logic [31:0] a);
    check({tag, ".valid"}, {31'b0, bus.err_valid}, {31'b0, v});
    check({tag, ".code"},  {31'b0, bus.err_code},  {31'b0, c});
    check({tag, ".addr"},  bus.err_addr, a);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int gnts;
    rst = 1'b1;
    bus.m_addr = '0; bus.m_wdata = '0; bus.m_we = 1'b0; bus.m_re = 1'b0;
    bus.m_hb = HB_WORD; bus.m_req = 1'b0; bus.err_clr = 1'b0;
    force_gnt = '0;
    for (int k = 0; k < NS; k++) begin
      gnt_delay[k] = 0;
      slv_data[k]  = 32'hC0DE_0000 | k;
    end
    slv_data[1] = 32'hDEAD_BEEF;
    repeat (3) @(negedge clk);
    check("rst.gnt",   {31'b0, bus.m_gnt}, 32'd0);
    check("rst.merr",  {31'b0, bus.m_err}, 32'd0);
    check("rst.rdata", bus.m_rdata, 32'd0);
    check("rst.ce",    bus.s_ce, 32'd0);
    check_err("rst", 1'b0, 1'b0, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Read slave 1, immediate grant.
    txn("rd1", 32'h9000_0010, 1'b0, 32'd0, 1'b0, 1'b0, 32'hDEAD_BEEF, 2, 1);
    // Write slave 5: rdata echoes the slave bus.
    slv_data[5] = 32'h5555_AAAA;
    txn("wr5", 32'hD000_0100, 1'b1, 32'h1234_0000, 1'b0, 1'b0, 32'h5555_AAAA, 2, 1);
    // Unmapped write.
    txn("miss", 32'h7000_0000, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'd0, 1, 0);
    check_err("miss", 1'b1, ERR_DECODE, 32'h7000_0000);
    clear_err();
    check("clr.valid", {31'b0, bus.err_valid}, 32'd0);

    // Slave 2 never grants: timeout after 4 WAIT cycles.
    gnt_delay[2] = -1;
    txn("tmo", 32'hA000_0000, 1'b0, 32'd0, 1'b0, 1'b1, 32'd0, 5, 4);
    check_err("tmo", 1'b1, ERR_TIMEOUT, 32'hA000_0000);
    txn("miss2", 32'h1234_5678, 1'b0, 32'd0, 1'b0, 1'b1, 32'd0, 1, 0);
    check_err("sticky", 1'b1, ERR_TIMEOUT, 32'hA000_0000);
    clear_err();

    // Grant on the exact timeout cycle wins.
    gnt_delay[3] = 3;
    txn("edge", 32'hB000_0004, 1'b0, 32'd0, 1'b0, 1'b0, 32'hC0DE_0003, 5, 4);
    check("edge.valid", {31'b0, bus.err_valid}, 32'd0);

    // Slave 3 granting while slave 0 is selected is ignored.
    gnt_delay[0] = 1;
    force_gnt[3] = 1'b1;
    txn("xgnt", 32'h8000_0020, 1'b0, 32'd0, 1'b0, 1'b0, 32'hC0DE_0000, 3, 2);
    force_gnt = '0;

    // Reset in WAIT aborts with no grant.
    txn("pre_rst", 32'h0000_0000, 1'b0, 32'd0, 1'b0, 1'b1, 32'd0, 1, 0);
    gnt_delay[4] = -1;
    @(negedge clk);
    bus.m_addr = 32'hC000_0000; bus.m_re = 1'b1; bus.m_req = 1'b1;
    @(posedge clk); #1;
    check("wrst.ce_on", bus.s_ce, 32'h10);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check("wrst.ce",    bus.s_ce, 32'd0);
    check("wrst.gnt",   {31'b0, bus.m_gnt}, 32'd0);
    check("wrst.rdata", bus.m_rdata, 32'd0);
    check_err("wrst", 1'b0, 1'b0, 32'd0);
    @(negedge clk);
    rst = 1'b0; bus.m_req = 1'b0; bus.m_re = 1'b0;
    gnts = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.m_gnt) gnts++;
    end
    check("wrst.nognt", gnts, 32'd0);

    // Clear coinciding with a new capture: capture wins.
    txn("errA", 32'h2000_0000, 1'b0, 32'd0, 1'b0, 1'b1, 32'd0, 1, 0);
    check_err("errA", 1'b1, ERR_DECODE, 32'h2000_0000);
    txn("errB", 32'h3000_0004, 1'b0, 32'd0, 1'b1, 1'b1, 32'd0, 1, 0);
    check_err("clrcap", 1'b1, ERR_DECODE, 32'h3000_0004);

    check("sb.empty", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
